// File: rtl/top_level_instantiation.sv
// ============================================================================
// Module   : top_level_instantiation
// Purpose  : Hamming(16,11) SECDED encoder engine with private byte memory
// Revision : 1.0
// ============================================================================
`default_nettype none

module top_level_dmem (
  input  logic       clock,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] core [0:255];

  always_ff @(posedge clock) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];
endmodule

module top_level_instantiation #(
  parameter int MSG_COUNT = 15,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 30
) (
  input  logic clock,
  input  logic req,
  output logic ack
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_LO = 3'd1,
    LD_HI = 3'd2,
    ST_LO = 3'd3,
    ST_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] c_src  = 8'(SRC_BASE);
  localparam logic [7:0] c_dst  = 8'(DST_BASE);
  localparam logic [3:0] c_last = 4'(MSG_COUNT - 1);

  state_t     r_state;
  logic [3:0] r_idx;
  logic [7:0] r_lo;
  logic [7:0] r_hi;

  logic [11:1] w_d;
  logic        w_p8, w_p4, w_p2, w_p1, w_p0;
  logic [7:0]  w_cw_lo, w_cw_hi;
  logic [7:0]  w_off;
  logic [7:0]  w_addr;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rdata;
  logic        w_we;
  logic        w_hi_unused;

  assign w_d         = {r_hi[2:0], r_lo};
  assign w_hi_unused = ^r_hi[7:3];

  assign w_p8 = ^w_d[11:5];
  assign w_p4 = (^w_d[11:8]) ^ (^w_d[4:2]);
  assign w_p2 = w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1];
  assign w_p1 = w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5] ^ w_d[4] ^ w_d[2] ^ w_d[1];
  assign w_p0 = (^w_d) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;

  assign w_cw_lo = {w_d[4], w_d[3], w_d[2], w_p4, w_d[1], w_p2, w_p1, w_p0};
  assign w_cw_hi = {w_d[11:5], w_p8};
  assign w_off   = {3'b000, r_idx, 1'b0};

  // Single shared port: address selects source or destination by state.
  // A pending req suppresses the store so a restart never touches memory.
  always_comb begin
    w_addr  = c_src + w_off;
    w_we    = 1'b0;
    w_wdata = w_cw_lo;
    case (r_state)
      LD_HI: w_addr = c_src + w_off + 8'd1;
      ST_LO: begin
        w_addr  = c_dst + w_off;
        w_we    = ~req;
        w_wdata = w_cw_lo;
      end
      ST_HI: begin
        w_addr  = c_dst + w_off + 8'd1;
        w_we    = ~req;
        w_wdata = w_cw_hi;
      end
      default: ;
    endcase
  end

  top_level_dmem DM (
    .clock (clock),
    .we    (w_we),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (req) begin
      r_state <= LD_LO;
      r_idx   <= 4'd0;
      ack     <= 1'b0;
    end else begin
      case (r_state)
        LD_LO: begin
          r_lo    <= w_rdata;
          r_state <= LD_HI;
        end
        LD_HI: begin
          r_hi    <= w_rdata;
          r_state <= ST_LO;
        end
        ST_LO: r_state <= ST_HI;
        ST_HI: begin
          if (r_idx == c_last) begin
            r_state <= DONE;
            ack     <= 1'b1;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= LD_LO;
          end
        end
        DONE:    ack <= 1'b1;
        default: begin
          r_state <= IDLE;
          ack     <= 1'b0;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_top_level_instantiation.sv
// Directed bench for the Hamming(16,11) encoder engine: preloads DM, runs, checks every byte.
`default_nettype none

module tb_top_level_instantiation;
  logic clock = 1'b0;
  logic req   = 1'b0;
  logic ack;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  img [0:255];
  logic [10:0] msg [0:14];

  top_level_instantiation dut (
    .clock (clock),
    .req   (req),
    .ack   (ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Positional Hamming model: codeword bit k is position k, parity at powers of two.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    int          j;
    cw = '0;
    j  = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        cw[k] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      logic p;
      p = 1'b0;
      for (int k = 1; k < 16; k++) if (((k >> b) & 1) == 1 && (k & (k - 1)) != 0) p ^= cw[k];
      cw[1 << b] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic preload(input logic fresh_msgs);
    for (int n = 0; n < 256; n++) begin
      img[n] = 8'($urandom);
      dut.DM.core[n] = img[n];
    end
    for (int i = 0; i < 15; i++) begin
      logic [4:0] junk;
      if (fresh_msgs) msg[i] = 11'($urandom);
      junk = 5'($urandom);
      img[2*i]   = msg[i][7:0];
      img[2*i+1] = {junk, msg[i][10:8]};
      dut.DM.core[2*i]   = img[2*i];
      dut.DM.core[2*i+1] = img[2*i+1];
    end
  endtask

  task automatic pulse_req(input int cycles);
    @(negedge clock);
    req = 1'b1;
    repeat (cycles) @(negedge clock);
    req = 1'b0;
    chk("ack_low_after_req", 32'(ack), 32'd0);
  endtask

  task automatic wait_ack(input string tag, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clock);
      #1;
      cnt++;
      if (ack === 1'b1) break;
    end
    chk(tag, 32'(cnt), 32'(exp_cycles));
  endtask

  task automatic verify(input string tag);
    int bad;
    bad = 0;
    for (int n = 0; n < 256; n++) begin
      logic [7:0] exp;
      logic [15:0] cw;
      exp = img[n];
      if (n >= 30 && n < 60) begin
        cw  = encode(msg[(n - 30) / 2]);
        exp = (n % 2 == 0) ? cw[7:0] : cw[15:8];
      end
      if (dut.DM.core[n] !== exp) begin
        bad++;
        $display("FAIL %s byte %0d got=%0h exp=%0h", tag, n, dut.DM.core[n], exp);
      end
    end
    chk({tag, "_bad_bytes"}, 32'(bad), 32'd0);
  endtask

  initial begin
    // Run 1: directed boundary messages in slots 0..3, random in the rest.
    for (int i = 0; i < 15; i++) msg[i] = 11'($urandom);
    msg[0] = 11'h000;
    msg[1] = 11'h7FF;
    msg[2] = 11'h001;
    msg[3] = 11'h400;
    preload(1'b0);
    pulse_req(1);
    repeat (59) @(posedge clock);
    #1;
    chk("ack_low_at_59", 32'(ack), 32'd0);
    @(posedge clock);
    #1;
    chk("ack_high_at_60", 32'(ack), 32'd1);
    chk("cw_000", 32'({dut.DM.core[31], dut.DM.core[30]}), 32'h0000);
    chk("cw_7ff", 32'({dut.DM.core[33], dut.DM.core[32]}), 32'hFFFF);
    chk("cw_001", 32'({dut.DM.core[35], dut.DM.core[34]}), 32'h000F);
    chk("cw_400", 32'({dut.DM.core[37], dut.DM.core[36]}), 32'h8117);
    verify("run1");
    repeat (5) @(posedge clock);
    #1;
    chk("ack_held", 32'(ack), 32'd1);

    // Run 2: fresh data, abort 20 cycles in, restart with req held 3 cycles.
    preload(1'b1);
    pulse_req(1);
    repeat (20) @(posedge clock);
    #1;
    chk("ack_low_mid_run", 32'(ack), 32'd0);
    pulse_req(3);
    wait_ack("abort_rerun_latency", 60);
    verify("run2");

    // Run 3: same messages, scrambled destination; output must be identical.
    preload(1'b0);
    pulse_req(2);
    wait_ack("rerun_latency", 60);
    verify("run3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
